// File: rtl/rv32_alu_arbiter_pkg.sv
// Shared types for the RV32 integer ALU and its request arbiter.
// rv32_types carries the base word type; rv32_alu_arbiter_pkg carries ALU op/flag types.
package rv32_types;
    typedef logic [31:0] rv32_word;
endpackage

package rv32_alu_arbiter_pkg;
    typedef rv32_types::rv32_word rv32_word;

    localparam int RV_ALU_OP_W = 68;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_opsel_t;

    typedef enum logic [1:0] {
        CMP_Z = 2'b00,
        CMP_P = 2'b01,
        CMP_N = 2'b10
    } cmp_flags_t;

    typedef struct packed {
        rv32_word   op1;
        rv32_word   op2;
        alu_opsel_t operation;
    } rv32_int_alu_operation;

    // Index width for an arbiter over n requesters; never narrower than one bit.
    function automatic int arb_id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic cmp_flags_t cmp_of(input logic lt, input logic eq);
        return eq ? CMP_Z : (lt ? CMP_N : CMP_P);
    endfunction
endpackage

// File: rtl/rv32_alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and rv32_alu_arbiter.
// req_lock exists only when RV_ALU_ARB_LOCK_EN is defined.
interface rv32_alu_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import rv32_alu_arbiter_pkg::*;

    logic [NUM_REQ-1:0]                        req_valid;
    logic [NUM_REQ-1:0]                        req_ready;
    rv32_int_alu_operation [NUM_REQ-1:0]       req_op;
    logic [NUM_REQ-1:0]                        resp_valid;
    logic [NUM_REQ-1:0]                        resp_ready;
    rv32_word                                  resp_result;
    cmp_flags_t                                resp_flags;
`ifdef RV_ALU_ARB_LOCK_EN
    logic [NUM_REQ-1:0]                        req_lock;
`endif

    modport master (
        output req_valid, req_op, resp_ready,
`ifdef RV_ALU_ARB_LOCK_EN
        output req_lock,
`endif
        input  req_ready, resp_valid, resp_result, resp_flags
    );

    modport slave (
        input  req_valid, req_op, resp_ready,
`ifdef RV_ALU_ARB_LOCK_EN
        input  req_lock,
`endif
        output req_ready, resp_valid, resp_result, resp_flags
    );
endinterface

// File: rtl/rv32_int_alu.sv
// Single-cycle RV32 integer ALU; compare ops flag op1 vs op2, other ops flag the result sign.
module rv32_int_alu
    import rv32_alu_arbiter_pkg::*;
(
    input  rv32_int_alu_operation op,
    output rv32_word              result,
    output cmp_flags_t            flags
);
    logic [4:0] shamt;
    assign shamt = op.op2[4:0];

    always_comb begin
        result = '0;
        flags  = CMP_Z;
        case (op.operation)
            ALU_ADD:  result = op.op1 + op.op2;
            ALU_SUB:  result = op.op1 - op.op2;
            ALU_SLL:  result = op.op1 << shamt;
            ALU_SLT:  result = {31'b0, $signed(op.op1) < $signed(op.op2)};
            ALU_SLTU: result = {31'b0, op.op1 < op.op2};
            ALU_XOR:  result = op.op1 ^ op.op2;
            ALU_SRL:  result = op.op1 >> shamt;
            ALU_SRA:  result = rv32_word'($signed(op.op1) >>> shamt);
            ALU_OR:   result = op.op1 | op.op2;
            ALU_AND:  result = op.op1 & op.op2;
            default:  result = '0;
        endcase
        case (op.operation)
            ALU_SLT:  flags = cmp_of($signed(op.op1) < $signed(op.op2), op.op1 == op.op2);
            ALU_SLTU: flags = cmp_of(op.op1 < op.op2, op.op1 == op.op2);
            default:  flags = cmp_of(result[31], result == '0);
        endcase
    end
endmodule

// File: rtl/rv32_rr_arbiter.sv
// Combinational one-hot round-robin grant: first valid & mask index at or after ptr, wrapping.
module rv32_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);
    always_comb begin
        int idx;
        idx    = 0;
        grant  = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!any && valid[idx] && mask[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/rv32_alu_arbiter.sv
// Round-robin sharing of one rv32_int_alu among NUM_REQ requesters with a one-entry response buffer.
// Optional grant locking for atomic sequences is enabled by RV_ALU_ARB_LOCK_EN.
module rv32_alu_arbiter
    import rv32_alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = arb_id_w(NUM_REQ)
) (
    input logic               clk,
    input logic               rst_n,
    rv32_alu_arbiter_if.slave bus
);
    logic                  out_valid;
    rv32_word              result_q;
    cmp_flags_t            flags_q;
    logic [ID_W-1:0]       owner, rr_ptr, gnt_id, ptr_nxt;
    logic [NUM_REQ-1:0]    grant, arb_mask;
    logic                  gnt_any, out_fire, space, accept, advance;
    rv32_int_alu_operation alu_in;
    rv32_word              alu_result;
    cmp_flags_t            alu_flags;

    assign out_fire = out_valid & bus.resp_ready[owner];
    assign space    = ~out_valid | out_fire;
    assign accept   = space & gnt_any;
    assign ptr_nxt  = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

`ifdef RV_ALU_ARB_LOCK_EN
    logic            locked;
    logic [ID_W-1:0] lock_id;

    // A held lock masks everyone but the holder and freezes the pointer.
    assign arb_mask = locked ? (NUM_REQ'(1) << lock_id) : '1;
    assign advance  = !(locked && bus.req_lock[gnt_id]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (accept) begin
            locked  <= bus.req_lock[gnt_id];
            lock_id <= gnt_id;
        end else if (locked && !bus.req_lock[lock_id] && !bus.req_valid[lock_id]) begin
            locked  <= 1'b0;
        end
    end
`else
    assign arb_mask = '1;
    assign advance  = 1'b1;
`endif

    rv32_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .valid  (bus.req_valid),
        .mask   (arb_mask),
        .ptr    (rr_ptr),
        .grant  (grant),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

    assign alu_in = gnt_any ? bus.req_op[gnt_id] : bus.req_op[0];

    rv32_int_alu u_alu (
        .op     (alu_in),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result_q  <= '0;
            flags_q   <= CMP_Z;
            owner     <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result_q  <= alu_result;
            flags_q   <= alu_flags;
            owner     <= gnt_id;
            if (advance) rr_ptr <= ptr_nxt;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.req_ready   = space ? grant : '0;
    assign bus.resp_result = result_q;
    assign bus.resp_flags  = flags_q;

    always_comb begin
        bus.resp_valid = '0;
        if (out_valid) bus.resp_valid[owner] = 1'b1;
    end
endmodule

// File: tb/tb_rv32_alu_arbiter.sv
// Directed bench for rv32_alu_arbiter (NUM_REQ=2); lock steps run when RV_ALU_ARB_LOCK_EN is defined.
module tb_rv32_alu_arbiter;
    import rv32_alu_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   n0, n1, w;
    logic [31:0] exp_res;

    rv32_alu_arbiter_if #(.NUM_REQ(2)) bus ();

    rv32_alu_arbiter #(.NUM_REQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rv32_int_alu_operation mk(input logic [31:0] a, input logic [31:0] b,
                                                 input alu_opsel_t o);
        rv32_int_alu_operation r;
        r.op1       = a;
        r.op2       = b;
        r.operation = o;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        bus.req_op     = '0;
`ifdef RV_ALU_ARB_LOCK_EN
        bus.req_lock   = '0;
`endif
        #3;
        chk("rst_resp_valid", bus.resp_valid, 2'b00);
        chk("rst_result", bus.resp_result, 32'd0);
        chk("rst_flags", bus.resp_flags, CMP_Z);
        chk("rst_req_ready", bus.req_ready, 2'b00);
        tick();
        rst_n = 1'b1;

        // Requester 0 alone: ADD 5+7
        bus.req_op[0]  = mk(32'd5, 32'd7, ALU_ADD);
        bus.req_valid  = 2'b01;
        bus.resp_ready = 2'b11;
        #1 chk("t1_ready", bus.req_ready, 2'b01);
        tick();
        chk("t1_resp_valid", bus.resp_valid, 2'b01);
        chk("t1_result", bus.resp_result, 32'd12);
        chk("t1_flags", bus.resp_flags, CMP_P);

        // Requester 1: SUB 3-3 then SLT -1<1
        bus.req_valid = 2'b10;
        bus.req_op[1] = mk(32'd3, 32'd3, ALU_SUB);
        #1 chk("t2a_ready", bus.req_ready, 2'b10);
        tick();
        chk("t2a_resp_valid", bus.resp_valid, 2'b10);
        chk("t2a_result", bus.resp_result, 32'd0);
        chk("t2a_flags", bus.resp_flags, CMP_Z);
        bus.req_op[1] = mk(32'hFFFF_FFFF, 32'd1, ALU_SLT);
        #1 chk("t2b_ready", bus.req_ready, 2'b10);
        tick();
        chk("t2b_resp_valid", bus.resp_valid, 2'b10);
        chk("t2b_result", bus.resp_result, 32'd1);
        chk("t2b_flags", bus.resp_flags, CMP_N);
        bus.req_valid = 2'b00;
        tick();
        chk("t2_drained", bus.resp_valid, 2'b00);

        // Both valid: alternating grants, one response per cycle
        n0 = 0;
        n1 = 0;
        bus.req_op[0] = mk(32'd0, 32'd1, ALU_ADD);
        bus.req_op[1] = mk(32'd200, 32'd0, ALU_SUB);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            w = k % 2;
            exp_res = (w == 0) ? 32'(10 * n0 + 1) : 32'(200 - n1);
            #1 chk("t3_ready", bus.req_ready, (w == 0) ? 2'b01 : 2'b10);
            tick();
            chk("t3_resp_valid", bus.resp_valid, (w == 0) ? 2'b01 : 2'b10);
            chk("t3_result", bus.resp_result, exp_res);
            if (w == 0) begin
                n0++;
                bus.req_op[0] = mk(32'(10 * n0), 32'd1, ALU_ADD);
            end else begin
                n1++;
                bus.req_op[1] = mk(32'd200, 32'(n1), ALU_SUB);
            end
        end

        // Owner 1 stalls; requester 0's ready must not drain the buffer
        bus.resp_ready = 2'b01;
        #1 chk("t4_ready_stall", bus.req_ready, 2'b00);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_hold_valid", bus.resp_valid, 2'b10);
            chk("t4_hold_result", bus.resp_result, 32'd198);
            chk("t4_hold_ready", bus.req_ready, 2'b00);
        end
        bus.resp_ready = 2'b11;
        #1 chk("t4_release_ready", bus.req_ready, 2'b01);
        tick();
        chk("t4_resp_valid", bus.resp_valid, 2'b01);
        chk("t4_result", bus.resp_result, 32'd31);
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b00;

        // Asynchronous reset while a response is buffered
        tick();
        chk("t5_pre_valid", bus.resp_valid, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", bus.resp_valid, 2'b00);
        chk("t5_rst_result", bus.resp_result, 32'd0);
        chk("t5_rst_flags", bus.resp_flags, CMP_Z);
        #1 rst_n = 1'b1;
        bus.req_op[0]  = mk(32'h7FFF_FFFF, 32'd1, ALU_ADD);
        bus.req_op[1]  = mk(32'd1, 32'd1, ALU_ADD);
        bus.req_valid  = 2'b11;
        bus.resp_ready = 2'b11;
        #1 chk("t5_ready", bus.req_ready, 2'b01);
        tick();
        chk("t5_resp_valid", bus.resp_valid, 2'b01);
        chk("t5_result", bus.resp_result, 32'h8000_0000);
        chk("t5_flags", bus.resp_flags, CMP_N);

        // Pointer at 1 but only requester 0 valid: wrap; illegal op yields 0
        bus.req_valid = 2'b01;
        bus.req_op[0] = mk(32'd9, 32'd9, alu_opsel_t'(4'hF));
        #1 chk("t5_wrap_ready", bus.req_ready, 2'b01);
        tick();
        chk("t5_illegal_valid", bus.resp_valid, 2'b01);
        chk("t5_illegal_result", bus.resp_result, 32'd0);
        chk("t5_illegal_flags", bus.resp_flags, CMP_Z);
        bus.req_valid = 2'b00;
        tick();
        chk("t5_drained", bus.resp_valid, 2'b00);

`ifdef RV_ALU_ARB_LOCK_EN
        // Requester 1 holds the grant for three ops while requester 0 waits
        bus.req_op[0] = mk(32'd50, 32'd50, ALU_ADD);
        bus.req_op[1] = mk(32'd1, 32'd1, ALU_ADD);
        bus.req_lock  = 2'b10;
        bus.req_valid = 2'b11;
        #1 chk("t6a_ready", bus.req_ready, 2'b10);
        tick();
        chk("t6a_resp_valid", bus.resp_valid, 2'b10);
        chk("t6a_result", bus.resp_result, 32'd2);
        bus.req_op[1] = mk(32'd2, 32'd2, ALU_ADD);
        #1 chk("t6b_ready", bus.req_ready, 2'b10);
        tick();
        chk("t6b_result", bus.resp_result, 32'd4);
        bus.req_op[1] = mk(32'd3, 32'd3, ALU_ADD);
        bus.req_lock  = 2'b00;
        #1 chk("t6c_ready", bus.req_ready, 2'b10);
        tick();
        chk("t6c_resp_valid", bus.resp_valid, 2'b10);
        chk("t6c_result", bus.resp_result, 32'd6);
        #1 chk("t6d_ready", bus.req_ready, 2'b01);
        tick();
        chk("t6d_resp_valid", bus.resp_valid, 2'b01);
        chk("t6d_result", bus.resp_result, 32'd100);
        bus.req_valid = 2'b00;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
